// File: rtl/ones_complement.sv
// ones_complement: registered pass-through / bitwise ones' complement of an
// operand, with a sticky valid flag and registered all-zero / all-ones flags.
module ones_complement #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inv,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             valid,
  output logic             is_zero,
  output logic             is_ones
);

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] o_d, o_q;
  logic             valid_d, valid_q;
  logic             is_zero_d, is_zero_q;
  logic             is_ones_d, is_ones_q;

  // Candidate result: each bit of i is flipped when inv is set, purely bitwise.
  always_comb begin
    load_val = i ^ {WIDTH{inv}};
  end

  // Next-state: load the new result on en; flags derive from the loaded value
  // so they always line up with o in the same cycle.
  always_comb begin
    o_d       = o_q;
    valid_d   = valid_q;
    is_zero_d = is_zero_q;
    is_ones_d = is_ones_q;
    if (en) begin
      o_d       = load_val;
      valid_d   = 1'b1;
      is_zero_d = (load_val == '0);
      is_ones_d = (load_val == '1);
    end
  end

  // State registers with asynchronous active-low reset to an empty, zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q       <= '0;
      valid_q   <= 1'b0;
      is_zero_q <= 1'b1;
      is_ones_q <= 1'b0;
    end else begin
      o_q       <= o_d;
      valid_q   <= valid_d;
      is_zero_q <= is_zero_d;
      is_ones_q <= is_ones_d;
    end
  end

  assign o       = o_q;
  assign valid   = valid_q;
  assign is_zero = is_zero_q;
  assign is_ones = is_ones_q;

endmodule

// File: tb/tb_ones_complement.sv
// tb_ones_complement: directed-vector bench for ones_complement (WIDTH=8).
module tb_ones_complement;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             inv;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] o;
  logic             valid;
  logic             is_zero;
  logic             is_ones;

  int unsigned tests_run;
  int unsigned tests_failed;

  ones_complement #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .inv     (inv),
    .i       (i),
    .o       (o),
    .valid   (valid),
    .is_zero (is_zero),
    .is_ones (is_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eo, input logic ev,
                           input logic ez, input logic e1);
    check_eq({tag, ".o"},       32'(o),       32'(eo));
    check_eq({tag, ".valid"},   32'(valid),   32'(ev));
    check_eq({tag, ".is_zero"}, 32'(is_zero), 32'(ez));
    check_eq({tag, ".is_ones"}, 32'(is_ones), 32'(e1));
  endtask

  // Apply inputs, then advance past the next rising edge to sample outputs.
  task automatic apply(input logic a_en, input logic a_inv, input logic [7:0] a_i);
    en  = a_en;
    inv = a_inv;
    i   = a_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_o;
    tests_run    = 0;
    tests_failed = 0;
    en    = 1'b0;
    inv   = 1'b0;
    i     = '0;
    rst_n = 1'b1;

    // Asynchronous reset with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_all("reset", 8'h00, 1'b0, 1'b1, 1'b0);

    // Edges with en=1 while held in reset are ignored.
    apply(1'b1, 1'b1, 8'h5A);
    check_all("reset_hold", 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    #1;

    // Complement and pass-through.
    apply(1'b1, 1'b1, 8'h5A);
    check_all("cpl_5a", 8'hA5, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 8'hFF);
    check_all("pass_ff", 8'hFF, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 8'hFF);
    check_all("cpl_ff", 8'h00, 1'b1, 1'b1, 1'b0);

    // Hold with en=0 while i and inv change.
    apply(1'b1, 1'b1, 8'h3C);
    check_all("load_3c", 8'hC3, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 5; k++) begin
      apply(1'b0, k[0], 8'h00);
      check_all("hold", 8'hC3, 1'b1, 1'b0, 1'b0);
    end

    // Mid-operation reset pulse between edges.
    #2 rst_n = 1'b0;
    #1;
    check_all("mid_reset", 8'h00, 1'b0, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
    apply(1'b0, 1'b1, 8'h77);
    check_all("post_reset_idle", 8'h00, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 8'h01);
    check_all("post_reset_load", 8'h01, 1'b1, 1'b0, 1'b0);

    // Exhaustive sweep, both operations.
    for (int unsigned m = 0; m < 2; m++) begin
      for (int unsigned v = 0; v < 256; v++) begin
        exp_o = (m == 1) ? ~8'(v) : 8'(v);
        apply(1'b1, m[0], 8'(v));
        check_all((m == 1) ? "sweep_inv" : "sweep_pass", exp_o, 1'b1,
                  exp_o == 8'h00, exp_o == 8'hFF);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ones_complement.md
ONES_COMPLEMENT -- requirements
Module: ones_complement

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits of i and o; SHALL support any WIDTH >= 2.
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port en  input  1  load enable; 1 = capture a new result this edge.
REQ-005 Port inv  input  1  operation select; 1 = ones' complement (~i), 0 = pass-through (i).
REQ-006 Port i  input  WIDTH  operand.
REQ-007 Port o  output  WIDTH  registered result.
REQ-008 Port valid  output  1  high while o holds a result captured since the last reset.
REQ-009 Port is_zero  output  1  registered flag; 1 when o == 0.
REQ-010 Port is_ones  output  1  registered flag; 1 when o == all ones ({WIDTH{1'b1}}).
REQ-011 Interface timing: one clock (clk); reset rst_n is asynchronous and active-low.

Function
REQ-012 On a rising clk edge with rst_n=1 and en=1, o SHALL load (inv ? ~i : i), bitwise over all WIDTH bits.
REQ-013 Latency SHALL be exactly 1 cycle from sampled i/inv/en to o, valid, is_zero and is_ones.
REQ-014 With en=0, o, valid, is_zero and is_ones SHALL hold their values; i and inv are ignored.
REQ-015 valid SHALL rise on the first edge with en=1 after reset and stay 1 until the next reset.
REQ-016 is_zero and is_ones SHALL be computed from the value being loaded into o, so they are never one cycle stale relative to o.
REQ-017 is_zero and is_ones SHALL never both be 1 (WIDTH >= 2).
REQ-018 No arithmetic, carry or sign handling; bit k of o depends only on bit k of i and on inv.
REQ-019 Outputs SHALL be driven only from registers; no combinational path from inputs to outputs.
REQ-020 en, inv and i SHALL be sampled together on the same edge; changing inv between edges with en=0 has no effect.

Reset
REQ-021 When rst_n=0, the block SHALL asynchronously, without waiting for clk, force o=0, valid=0, is_zero=1 and is_ones=0.
REQ-022 While rst_n=0, all clk edges SHALL be ignored, including those with en=1.
REQ-023 Reset asserted mid-operation SHALL discard the held result; the first en=1 edge after release produces a fresh result.
REQ-024 Reset release SHALL be synchronized by the integrator; the block needs no internal release logic beyond standard async-reset flops.

Verification
REQ-025 Reset: rst_n=0 with no clk edge -> o=0x00, valid=0, is_zero=1, is_ones=0 immediately.
REQ-026 Complement: WIDTH=8, en=1, inv=1, i=0x5A -> next edge o=0xA5, valid=1, is_zero=0, is_ones=0.
REQ-027 Pass-through and flags: en=1, inv=0, i=0xFF -> o=0xFF, is_ones=1; then inv=1, i=0xFF -> o=0x00, is_zero=1.
REQ-028 Hold: load 0x3C with inv=1 (o=0xC3), then en=0 with i=0x00 and inv toggling for 5 cycles -> o stays 0xC3.
REQ-029 Mid-operation reset: after o=0xC3, pulse rst_n low between edges -> o=0, valid=0 at once; next en=1, inv=0, i=0x01 edge -> o=0x01, valid=1.
REQ-030 Exhaustive: WIDTH=8, sweep all 256 i values with inv=0 and inv=1 -> o equals i and ~i respectively; flags match o every cycle.
